flash_writer: RTL

- Single-bit SPI program/erase engine for the same W25Q128-class flash that the DSPI read path uses, so the core can write back save data, such as disk images, into the usable area that starts at 8 MB.
- Accepts one host command at a time: page program or 4 KB sector erase.
- Issues Write Enable, then the command, then polls the status register until the flash is no longer busy.
- Top-level muxing hands the flash pins to this block only while the read path is idle.

---
 rtl/flash_writer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/flash_writer.sv
`default_nettype none
// ============================================================================
// Module      : flash_writer
// Description : Single-bit SPI program / 4 KB sector-erase engine for a
//               W25Q128-class flash. It sends WREN, then the program or erase
//               command with its 24-bit address (plus data words for a
//               program), then polls RDSR until the flash reports not busy.
// Ports       : clk, reset             - clock, synchronous active-high reset
//               start/op/address/nwords - host command (sampled when busy=0)
//               data_in/data_valid/data_ready - program data handshake
//               busy/done/error         - command status
//               mspi_*                  - SPI flash pins (mode 0)
// Revision    : 1.0 - initial release
// ============================================================================
module flash_writer #(
  parameter int          CS_GAP   = 4,
  parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [21:0] address,
  input  logic [7:0]  nwords,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mspi_cs,
  output logic        mspi_clk,
  output logic        mspi_di,
  input  logic        mspi_do,
  output logic        mspi_wp,
  output logic        mspi_hold
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHECK = 4'd1,
    S_WREN  = 4'd2,
    S_GAP   = 4'd3,
    S_CMD   = 4'd4,
    S_ADDR  = 4'd5,
    S_DATA  = 4'd6,
    S_POLL  = 4'd7,
    S_FIN   = 4'd8
  } state_t;

  state_t      state, state_n;
  logic        phase;        // 0: clock low, 1: clock high
  logic [2:0]  bitcnt;
  logic [1:0]  bytecnt;      // byte index inside the current cs-low state
  logic [7:0]  sr;           // outgoing byte, MSB on the pin
  logic [7:0]  lo_byte;      // odd byte of the word being programmed
  logic [7:0]  wordcnt;
  logic [23:0] pollcnt;
  logic [15:0] gapcnt;
  logic        gap_to_poll;  // GAP exits to POLL instead of CMD
  logic        op_r, err_r;
  logic [21:0] addr_r;
  logic [7:0]  nwords_r;

  logic        sending, word_start, stall, byte_end;
  logic        req_bad, reject, poll_last, poll_timeout;
  logic [23:0] byte_addr, cmd_addr;
  logic [7:0]  load_byte, next_byte;

  assign sending    = (state == S_WREN) || (state == S_CMD) || (state == S_ADDR) ||
                      (state == S_DATA) || (state == S_POLL);
  // A word starts at phase 0 of the first bit of every even data byte.
  assign word_start = (state == S_DATA) && !phase && (bitcnt == 3'd0) && !bytecnt[0];
  assign stall      = word_start && !data_valid;
  assign byte_end   = sending && phase && (bitcnt == 3'd7);

  assign byte_addr  = {1'b1, addr_r, 1'b0};
  assign cmd_addr   = op_r ? {byte_addr[23:12], 12'h000} : byte_addr;

  // Program must stay inside one 256-byte page (128 words).
  assign req_bad    = (nwords_r == 8'd0) || (nwords_r > 8'd128) ||
                      (({2'b00, addr_r[6:0]} + {1'b0, nwords_r}) > 9'd128);
  assign reject     = (state == S_CHECK) && !op_r && req_bad;
  // Status bit0 is the last bit of the status byte, so mspi_do is live here.
  assign poll_last    = (state == S_POLL) && byte_end && bytecnt[0];
  assign poll_timeout = poll_last && mspi_do && (pollcnt == POLL_MAX - 24'd1);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_CHECK;
      S_CHECK: state_n = reject ? S_FIN : S_WREN;
      S_WREN:  if (byte_end) state_n = S_GAP;
      S_GAP:   if (gapcnt == 16'(CS_GAP - 1)) state_n = gap_to_poll ? S_POLL : S_CMD;
      S_CMD:   if (byte_end) state_n = S_ADDR;
      S_ADDR:  if (byte_end && (bytecnt == 2'd2)) state_n = op_r ? S_GAP : S_DATA;
      S_DATA:  if (byte_end && bytecnt[0] && (wordcnt == nwords_r - 8'd1)) state_n = S_GAP;
      S_POLL:  if (poll_last) state_n = (!mspi_do || poll_timeout) ? S_FIN : S_GAP;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // First byte shifted out when a state is entered.
  always_comb begin
    load_byte = 8'h00;
    case (state_n)
      S_WREN:  load_byte = 8'h06;
      S_CMD:   load_byte = op_r ? 8'h20 : 8'h02;
      S_ADDR:  load_byte = cmd_addr[23:16];
      S_POLL:  load_byte = 8'h05;
      default: load_byte = 8'h00;
    endcase
  end

  // Following byte inside the same state.
  always_comb begin
    next_byte = 8'h00;
    case (state)
      S_ADDR:  next_byte = (bytecnt == 2'd0) ? cmd_addr[15:8] : cmd_addr[7:0];
      S_DATA:  next_byte = bytecnt[0] ? 8'h00 : lo_byte;
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      bitcnt      <= 3'd0;
      bytecnt     <= 2'd0;
      sr          <= 8'h00;
      lo_byte     <= 8'h00;
      wordcnt     <= 8'd0;
      pollcnt     <= 24'd0;
      gapcnt      <= 16'd0;
      gap_to_poll <= 1'b0;
      op_r        <= 1'b0;
      addr_r      <= 22'd0;
      nwords_r    <= 8'd0;
      err_r       <= 1'b0;
    end else begin
      state <= state_n;
      if ((state == S_IDLE) && start) begin
        op_r     <= op;
        addr_r   <= address;
        nwords_r <= nwords;
        err_r    <= 1'b0;
        wordcnt  <= 8'd0;
        pollcnt  <= 24'd0;
      end
      if (reject || poll_timeout) err_r <= 1'b1;
      if (state == S_GAP) gapcnt <= gapcnt + 16'd1;
      if (word_start && data_valid) begin
        sr      <= data_in[15:8];
        lo_byte <= data_in[7:0];
      end
      if (sending && !stall) begin
        phase <= ~phase;
        if (phase) begin
          bitcnt <= bitcnt + 3'd1;
          sr     <= {sr[6:0], 1'b0};
          if (bitcnt == 3'd7) begin
            bytecnt <= bytecnt + 2'd1;
            sr      <= next_byte;
            if ((state == S_DATA) && bytecnt[0]) wordcnt <= wordcnt + 8'd1;
            if (poll_last) pollcnt <= pollcnt + 24'd1;
          end
        end
      end
      // State entry: restart bit timing with the clock low.
      if (state_n != state) begin
        phase   <= 1'b0;
        bitcnt  <= 3'd0;
        bytecnt <= 2'd0;
        gapcnt  <= 16'd0;
        sr      <= load_byte;
        if (state_n == S_GAP) gap_to_poll <= (state != S_WREN);
      end
    end
  end

  assign busy       = (state != S_IDLE) && (state != S_FIN);
  assign done       = (state == S_FIN);
  assign error      = (state == S_FIN) && err_r;
  assign data_ready = word_start;
  assign mspi_cs    = !sending;
  assign mspi_clk   = phase;
  // The first bit of a word goes straight from data_in so the word can be
  // accepted in the same cycle that drives its MSB.
  assign mspi_di    = word_start ? data_in[15] : sr[7];
  assign mspi_wp    = 1'b1;
  assign mspi_hold  = 1'b1;

endmodule
`default_nettype wire
